// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable game timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider: counts 0..TICK_DIV-1 while run is high and flags the last count.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter  int unsigned TICK_DIV = 5000000,
  localparam int unsigned PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic clock,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [PS_W-1:0] LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + PS_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable down-counting tick timer: one-shot or periodic, with pause/resume,
// sticky expiry flag and readable remaining tick count.
module prog_timer
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             stop_in,
  input  logic             resume,
  input  logic             clear,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  output logic             time_out,
  output logic             expired,
  output logic             running,
  output logic [CNT_W-1:0] remaining
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic             mode_q, mode_d;
  logic             time_out_q, time_out_d;
  logic             expired_q, expired_d;
  logic             ps_run, ps_clr, tick;

  // Prescaler only advances on a RUN cycle nothing higher-priority overrides;
  // a stop on a tick cycle therefore freezes it at its last count.
  assign ps_run = (state_q == RUN) && !clear && !enable && !stop_in;
  assign ps_clr = clear || enable;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock (clock),
    .rst   (rst),
    .run   (ps_run),
    .clr   (ps_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    load_d      = load_q;
    mode_d      = mode_q;
    time_out_d  = 1'b0;
    expired_d   = expired_q;

    if (clear) begin
      state_d     = IDLE;
      remaining_d = '0;
      expired_d   = 1'b0;
    end else if (enable) begin
      load_d      = load_val;
      mode_d      = periodic;
      remaining_d = load_val;
      if (load_val == '0) begin
        state_d    = DONE;
        time_out_d = 1'b1;
        expired_d  = 1'b1;
      end else begin
        state_d   = RUN;
        expired_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (stop_in) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (remaining_q > CNT_W'(1)) begin
              remaining_d = remaining_q - CNT_W'(1);
            end else if (remaining_q == CNT_W'(1)) begin
              time_out_d = 1'b1;
              expired_d  = 1'b1;
              if (mode_q == MODE_PERIODIC) begin
                remaining_d = load_q;
              end else begin
                remaining_d = '0;
                state_d     = DONE;
              end
            end
          end
        end
        PAUSE: begin
          if (resume) begin
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      load_q      <= '0;
      mode_q      <= MODE_ONESHOT;
      time_out_q  <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      load_q      <= load_d;
      mode_q      <= mode_d;
      time_out_q  <= time_out_d;
      expired_q   <= expired_d;
    end
  end

  assign time_out  = time_out_q;
  assign expired   = expired_q;
  assign running   = (state_q == RUN);
  assign remaining = remaining_q;

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: two instances (TICK_DIV 4 and 1) share
// stimulus; an elapsed-cycle reference model predicts their outputs.
`timescale 1ps/1ps
module tb_prog_timer;

  logic       clock, rst;
  logic       enable, stop_in, resume, clear, periodic;
  logic [7:0] load_val;
  logic       time_out4, expired4, running4;
  logic [7:0] remaining4;
  logic       time_out1, expired1, running1;
  logic [7:0] remaining1;

  prog_timer #(.CNT_W(8), .TICK_DIV(4)) u4 (
    .clock(clock), .rst(rst), .enable(enable), .stop_in(stop_in), .resume(resume),
    .clear(clear), .periodic(periodic), .load_val(load_val),
    .time_out(time_out4), .expired(expired4), .running(running4), .remaining(remaining4)
  );

  prog_timer #(.CNT_W(8), .TICK_DIV(1)) u1 (
    .clock(clock), .rst(rst), .enable(enable), .stop_in(stop_in), .resume(resume),
    .clear(clear), .periodic(periodic), .load_val(load_val),
    .time_out(time_out1), .expired(expired1), .running(running1), .remaining(remaining1)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Model: a load of N with divide D expires after N*D advancing cycles.
  typedef struct {
    bit active;
    bit paused;
    bit expired;
    bit to;
    bit per;
    int load;
    int elapsed;
  } mdl_t;

  typedef struct {
    int tag;
    int to4, ex4, rn4, rm4;
    int to1, ex1, rn1, rm1;
  } exp_t;

  mdl_t m4, m1;
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic mdl_t mstep(mdl_t m, bit c, bit e, bit s, bit r, bit p, int lv, int d);
    m.to = 1'b0;
    if (c) begin
      m.active = 0; m.paused = 0; m.expired = 0; m.elapsed = 0;
    end else if (e) begin
      m.load = lv; m.per = p; m.elapsed = 0; m.paused = 0;
      m.active  = (lv != 0);
      m.expired = (lv == 0);
      m.to      = (lv == 0);
    end else if (m.active && !m.paused) begin
      if (s) m.paused = 1;
      else begin
        m.elapsed++;
        if (m.elapsed == m.load * d) begin
          m.to = 1; m.expired = 1; m.elapsed = 0;
          m.active = m.per;
        end
      end
    end else if (m.active && r) begin
      m.paused = 0;
    end
    return m;
  endfunction

  function automatic int m_rem(mdl_t m, int d);
    return m.active ? m.load - m.elapsed / d : 0;
  endfunction

  task automatic chk(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic push_exp();
    exp_t x;
    x.tag = cyc + 1;
    x.to4 = m4.to; x.ex4 = m4.expired; x.rn4 = m4.active && !m4.paused; x.rm4 = m_rem(m4, 4);
    x.to1 = m1.to; x.ex1 = m1.expired; x.rn1 = m1.active && !m1.paused; x.rm1 = m_rem(m1, 1);
    q.push_back(x);
  endtask

  task automatic step(bit c, bit e, bit s, bit r, bit p, int lv);
    @(posedge clock);
    #2;
    clear = c; enable = e; stop_in = s; resume = r; periodic = p;
    load_val = 8'(lv);
    m4 = mstep(m4, c, e, s, r, p, lv & 255, 4);
    m1 = mstep(m1, c, e, s, r, p, lv & 255, 1);
    push_exp();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
  endtask

  task automatic check_zero_outputs(string tag);
    chk({tag, "_to4"}, int'(time_out4), 0);
    chk({tag, "_ex4"}, int'(expired4), 0);
    chk({tag, "_rn4"}, int'(running4), 0);
    chk({tag, "_rm4"}, int'(remaining4), 0);
    chk({tag, "_rm1"}, int'(remaining1), 0);
    chk({tag, "_rn1"}, int'(running1), 0);
  endtask

  task automatic release_reset();
    clear = 0; enable = 0; stop_in = 0; resume = 0; periodic = 0; load_val = '0;
    repeat (2) @(posedge clock);
    #2;
    rst = 1'b1;
    m4 = mstep(m4, 0, 0, 0, 0, 0, 0, 4);
    m1 = mstep(m1, 0, 0, 0, 0, 0, 0, 1);
    push_exp();
  endtask

  task automatic async_reset();
    @(posedge clock);
    #5;
    rst = 1'b0;
    q.delete();
    #1;
    check_zero_outputs("async_rst");
    m4 = '{default: 0};
    m1 = '{default: 0};
    release_reset();
  endtask

  // Monitor: compare every expectation whose edge has already happened.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        chk("time_out4",  int'(time_out4),  e.to4);
        chk("expired4",   int'(expired4),   e.ex4);
        chk("running4",   int'(running4),   e.rn4);
        chk("remaining4", int'(remaining4), e.rm4);
        chk("time_out1",  int'(time_out1),  e.to1);
        chk("expired1",   int'(expired1),   e.ex1);
        chk("running1",   int'(running1),   e.rn1);
        chk("remaining1", int'(remaining1), e.rm1);
      end
    end
  end

  initial begin
    rst = 1'b0;
    clear = 0; enable = 0; stop_in = 0; resume = 0; periodic = 0; load_val = '0;
    m4 = '{default: 0};
    m1 = '{default: 0};
    #1;
    check_zero_outputs("reset");
    release_reset();
    idle(3);

    // one-shot load 5
    step(0, 1, 0, 0, 0, 5);
    idle(25);

    // periodic load 3, load_val changes ignored, then clear
    step(0, 1, 0, 0, 1, 3);
    idle(4);
    for (int i = 0; i < 35; i++) step(0, 0, 0, 0, 0, 7);
    step(1, 0, 0, 0, 0, 7);
    idle(5);

    // pause for 10 cycles, then resume
    step(0, 1, 0, 0, 0, 5);
    idle(5);
    step(0, 0, 1, 0, 0, 0);
    idle(9);
    step(0, 0, 0, 1, 0, 0);
    idle(20);

    // stop on a tick cycle
    step(0, 1, 0, 0, 0, 3);
    idle(3);
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    step(0, 0, 0, 1, 0, 0);
    idle(12);

    // zero load in both modes
    step(0, 1, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 0, 1, 0);
    idle(3);

    // restart during RUN with remaining 3
    step(0, 1, 0, 0, 0, 5);
    idle(8);
    step(0, 1, 0, 0, 0, 2);
    idle(12);

    // priority: clear+enable, then stop+resume in RUN
    step(1, 1, 0, 0, 1, 6);
    idle(3);
    step(0, 1, 0, 0, 1, 6);
    idle(2);
    step(0, 0, 1, 1, 0, 0);
    idle(4);
    step(0, 0, 0, 1, 0, 0);
    idle(3);

    // asynchronous reset mid-RUN
    step(0, 1, 0, 0, 1, 9);
    idle(6);
    async_reset();
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit c, e, s, r, p;
      int lv;
      c  = ($urandom_range(0, 99) < 2);
      e  = ($urandom_range(0, 99) < 6);
      s  = ($urandom_range(0, 99) < 5);
      r  = ($urandom_range(0, 99) < 12);
      p  = 1'($urandom_range(0, 1));
      lv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 12));
      step(c, e, s, r, p, lv);
    end

    idle(2);
    repeat (2) @(posedge clock);
    #12;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
